// File: rtl/serial_adder_if.sv
// serial_adder_if -- request/result bundle for the bit-serial adder.
//
// Handshake: the requester raises start together with a, b and cin; the
// request is taken on the first rising clk edge where the adder is idle
// (busy=0 and done=0). Requests made while busy or done is high are
// dropped, not queued. done is a one-cycle pulse; sum/cout are valid from
// that cycle until the first shift edge of the next accepted request.
//
// Signals:
//   start  requester -> adder   request to add a + b + cin
//   a, b   requester -> adder   WIDTH-bit operands
//   cin    requester -> adder   carry-in
//   busy   adder -> requester   bits are being processed
//   done   adder -> requester   one-cycle result-valid pulse
//   sum    adder -> requester   WIDTH-bit registered result
//   cout   adder -> requester   registered carry-out
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial adder computing a + b + cin, LSB first, one bit
// per clock through a single full-adder cell and a carry flip-flop.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      asynchronous, active-high reset
//   bus      serial_adder_if slave: start/a/b/cin in, busy/done/sum/cout out
//   state_o  current FSM state (0=IDLE, 1=SHIFT, 2=DONE) for observation
//
// An operation takes WIDTH+2 cycles: IDLE (accept), WIDTH x SHIFT, DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus,
    output logic [1:0]    state_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    // The single full-adder cell, fed by the operand LSBs and the carry flop.
    assign fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_c     = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values. sum/cout are left alone on accept so the previous
    // result stays readable until the first shift edge overwrites sum.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB; after WIDTH shifts bit 0
                // has travelled down to position 0.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) cout_d = fa_c;
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.busy = (state_q == SHIFT);
        bus.done = (state_q == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
        state_o  = state_q;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to add a, b and cin; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 cin  input  1  carry-in, captured when start is accepted.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 sum  output  WIDTH  registered result, bit i = sum bit i of a+b+cin.
REQ-011 cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 The block SHALL compute a+b+cin bit-serially, LSB first, one bit per clock, using a single 1-bit full-adder cell (s = x^y^c, c' = x&y | (x^y)&c) and a carry flip-flop.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 IDLE: start=1 at a rising edge SHALL load a and b into operand shift registers, cin into the carry flop, clear the bit counter, and move to SHIFT; start=0 stays IDLE.
REQ-015 SHIFT: each rising edge SHALL add operand bit 0s with the carry flop, shift the result bit into the sum register MSB (sum register shifts right), update the carry flop, shift both operands right by one, and increment the counter.
REQ-016 SHIFT SHALL last exactly WIDTH edges; the edge processing bit WIDTH-1 SHALL move to DONE and write the final carry to cout.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-018 Latency: with start accepted at edge E, done SHALL be high in the cycle following edge E+WIDTH and low otherwise.
REQ-019 busy SHALL equal (state == SHIFT); done SHALL equal (state == DONE); both are decoded from registered state only.
REQ-020 sum and cout SHALL hold the last completed result from DONE until the next accepted start's first SHIFT edge; intermediate sum bits are not valid while busy=1.
REQ-021 start SHALL be ignored while busy=1 or in DONE; operands in flight SHALL NOT be modified by a, b, cin changes.
REQ-022 start held high continuously SHALL produce back-to-back additions, one accepted per WIDTH+2 cycles (IDLE, WIDTH x SHIFT, DONE).
REQ-023 Bit counter width SHALL be ceil(log2(WIDTH))+1 bits; no wrap-around occurs within one operation.
REQ-024 Overflow SHALL not be flagged separately; the full result is {cout, sum}.

Reset
REQ-025 rst=1 SHALL immediately, without a clock, force state IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, operand registers=0.
REQ-026 rst asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow for it.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 WIDTH=8: a=0x00, b=0x00, cin=0, start pulse -> done after 8 SHIFT edges, sum=0x00, cout=0.
REQ-029 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-030 WIDTH=8: a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0; busy high exactly 8 cycles, done high exactly 1 cycle.
REQ-031 Start 0x10+0x20, then at SHIFT cycle 3 pulse start with a=0xFF, b=0xFF -> second request ignored, sum=0x30, cout=0.
REQ-032 Start 0xFF+0xFF, assert rst at SHIFT cycle 4 -> busy, done, sum, cout all 0 immediately, no done pulse; next start 0x01+0x01 -> sum=0x02.
REQ-033 WIDTH=4 exhaustive: all 512 a/b/cin combinations -> {cout,sum} equals a+b+cin in every case; start held high gives done every 6 cycles.
